y_requant_8: RTL and testbench

Y_REQUANT_8 -- requirements
Module: y_requant_8

---
 rtl/y_requant_8.sv | 129 ++++++++++++
 tb/tb_y_requant_8.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/y_requant_8.sv
// Requantizes 18-bit signed conv results to 8-bit signed (round, shift, saturate), tags group ends, buffers in a small FIFO.
// Optional macro Y_REQUANT_RELU_EN clamps negative inputs to zero.
module y_requant_8 #(
    parameter int unsigned SHIFT = 4,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned FRAME = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [17:0] s_data_in_y,
    input  logic        s_valid_y,
    output logic        s_ready_y,
    output logic [7:0]  m_data_out_z,
    output logic        m_valid_z,
    input  logic        m_ready_z,
    output logic        m_last_z,
    output logic        sat_seen
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam int unsigned GW = (FRAME > 1) ? $clog2(FRAME) : 1;
    localparam int unsigned EW = 9;

    logic [EW-1:0] mem_q [DEPTH];
    logic [EW-1:0] mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [GW-1:0] grp_q, grp_d;
    logic          sat_q, sat_d;
    logic          ready_q, ready_d;
    logic          valid_q, valid_d;
    logic [7:0]    data_q, data_d;
    logic          last_q, last_d;

    logic signed [18:0] t_c;
    logic signed [18:0] r_c;
    logic [7:0]         val_c;
    logic               sat_c;
    logic               push_c;
    logic               pop_c;

    // Round-half-up then floor shift, clamp to int8.
    always_comb begin
        t_c   = {s_data_in_y[17], s_data_in_y} + 19'(1 << (SHIFT - 1));
        r_c   = t_c >>> SHIFT;
        val_c = r_c[7:0];
        sat_c = 1'b0;
        if (r_c > 19'sd127) begin
            val_c = 8'h7f;
            sat_c = 1'b1;
        end else if (r_c < -19'sd128) begin
            val_c = 8'h80;
            sat_c = 1'b1;
        end
`ifdef Y_REQUANT_RELU_EN
        if (s_data_in_y[17]) begin
            val_c = 8'h00;
            sat_c = 1'b0;
        end
`endif
    end

    // FIFO bookkeeping; output registers preload the next head entry.
    always_comb begin
        push_c   = s_valid_y & ready_q;
        pop_c    = valid_q & m_ready_z;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        grp_d    = grp_q;
        sat_d    = sat_q;
        data_d   = data_q;
        last_d   = last_q;

        if (push_c) begin
            mem_d[wr_ptr_q] = {(grp_q == GW'(FRAME - 1)), val_c};
            wr_ptr_d        = wr_ptr_q + PW'(1);
            grp_d           = (grp_q == GW'(FRAME - 1)) ? '0 : grp_q + GW'(1);
            sat_d           = sat_q | sat_c;
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        count_d = count_q + CW'(push_c) - CW'(pop_c);
        ready_d = (count_d < CW'(DEPTH));
        valid_d = (count_d != '0);
        if (valid_d) begin
            {last_d, data_d} = mem_d[rd_ptr_d];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            grp_q    <= '0;
            sat_q    <= 1'b0;
            ready_q  <= 1'b0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            last_q   <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            grp_q    <= grp_d;
            sat_q    <= sat_d;
            ready_q  <= ready_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            last_q   <= last_d;
        end
    end

    assign s_ready_y    = ready_q;
    assign m_valid_z    = valid_q;
    assign m_data_out_z = data_q;
    assign m_last_z     = last_q;
    assign sat_seen     = sat_q;

endmodule

// File: tb/tb_y_requant_8.sv
// Scoreboard bench for y_requant_8: randomized and directed stimulus against an arithmetic reference model.
module tb_y_requant_8;

    localparam int SHIFT = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 5;

    logic        clk;
    logic        reset;
    logic [17:0] s_data_in_y;
    logic        s_valid_y;
    logic        s_ready_y;
    logic [7:0]  m_data_out_z;
    logic        m_valid_z;
    logic        m_ready_z;
    logic        m_last_z;
    logic        sat_seen;

    int checks   = 0;
    int failures = 0;
    int pops     = 0;
    int n_acc    = 0;
    bit sat_exp  = 0;
    bit rand_rdy = 0;
    logic [8:0] exp_q[$];

    y_requant_8 #(.SHIFT(SHIFT), .DEPTH(DEPTH), .FRAME(FRAME)) dut (
        .clk(clk), .reset(reset), .s_data_in_y(s_data_in_y), .s_valid_y(s_valid_y),
        .s_ready_y(s_ready_y), .m_data_out_z(m_data_out_z), .m_valid_z(m_valid_z),
        .m_ready_z(m_ready_z), .m_last_z(m_last_z), .sat_seen(sat_seen)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: round-to-nearest (half up) division by 2^SHIFT, then clamp.
    function automatic int model(input int y, output bit sat);
        int d;
        int t;
        int r;
        d   = 2 ** SHIFT;
        t   = y + d / 2;
        r   = (t >= 0) ? t / d : -((-t + d - 1) / d);
        sat = 0;
`ifdef Y_REQUANT_RELU_EN
        if (y < 0) return 0;
`endif
        if (r > 127) begin r = 127; sat = 1; end
        if (r < -128) begin r = -128; sat = 1; end
        return r;
    endfunction

    // Offer one value until accepted; expected result is queued when acceptance is seen.
    task automatic send(input int y);
        bit s;
        int r;
        bit done;
        done        = 0;
        s_valid_y   = 1;
        s_data_in_y = 18'(y);
        for (int c = 0; c < 1000 && !done; c++) begin
            @(negedge clk);
            if (s_ready_y) begin
                r = model(y, s);
                exp_q.push_back({(n_acc % FRAME == FRAME - 1), 8'(r)});
                n_acc++;
                sat_exp = sat_exp | s;
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            failures++;
            checks++;
            $display("FAIL send_timeout: value %0d not accepted", y);
        end
        s_valid_y   = 0;
        s_data_in_y = 'x;
    endtask

    task automatic do_reset();
        reset = 1;
        exp_q.delete();
        n_acc   = 0;
        sat_exp = 0;
        @(negedge clk);
        chk("rst_ready", 32'(s_ready_y), 0);
        chk("rst_valid", 32'(m_valid_z), 0);
        chk("rst_data", 32'(m_data_out_z), 0);
        chk("rst_last", 32'(m_last_z), 0);
        chk("rst_sat", 32'(sat_seen), 0);
        @(posedge clk);
        #1;
        reset = 0;
        @(posedge clk);
        #1;
        chk("ready_after_rst", 32'(s_ready_y), 1);
    endtask

    task automatic drain(input int limit);
        for (int c = 0; c < limit && exp_q.size() != 0; c++) @(posedge clk);
        #1;
        chk("drain_empty", 32'(exp_q.size()), 0);
    endtask

    // Monitor: compare presented head against scoreboard, pop on handshake.
    always @(negedge clk) begin
        if (!reset && m_valid_z) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output: data %0h with empty scoreboard", m_data_out_z);
            end else begin
                chk("data", 32'(m_data_out_z), 32'(exp_q[0][7:0]));
                chk("last", 32'(m_last_z), 32'(exp_q[0][8]));
                if (m_ready_z) begin
                    void'(exp_q.pop_front());
                    pops++;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            m_ready_z = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        int p0;
        int y;
        reset       = 1;
        s_valid_y   = 0;
        s_data_in_y = 'x;
        m_ready_z   = 0;
        #12;
        do_reset();

        // Basic rounding and one-cycle latency.
        m_ready_z = 1;
        send(100);
        chk("latency_valid", 32'(m_valid_z), 1);
        send(-100);
        send(8);
        send(-8);
        send(-9);
        drain(20);
        chk("sat_clear", 32'(sat_seen), 0);

        // Saturation both directions, sticky flag.
        send(131071);
        chk("sat_pos", 32'(sat_seen), 32'(sat_exp));
        send(-131072);
        send(50);
        chk("sat_sticky", 32'(sat_seen), 1);
        drain(20);
        do_reset();

        // Backpressure: FIFO fills, head holds, then drains in order.
        m_ready_z = 0;
        fork
            begin
                for (int i = 0; i < 6; i++) send(i * 300 - 700);
            end
            begin
                repeat (8) @(posedge clk);
                #1;
                chk("full_ready_low", 32'(s_ready_y), 0);
                chk("full_valid", 32'(m_valid_z), 1);
                chk("full_count", 32'(exp_q.size()), 4);
                m_ready_z = 1;
            end
        join
        drain(30);
        do_reset();

        // Continuous stream: one output per cycle, last on 5th and 10th.
        m_ready_z = 1;
        p0 = pops;
        for (int i = 0; i < 10; i++) send(i * 16);
        chk("stream_pops_inflight", 32'(pops - p0), 9);
        @(posedge clk);
        #1;
        chk("stream_pops", 32'(pops - p0), 10);
        chk("stream_idle", 32'(m_valid_z), 0);

        // Reset mid-operation discards entries and restarts grouping.
        m_ready_z = 0;
        for (int i = 0; i < 3; i++) send(1000 + i);
        reset = 1;
        exp_q.delete();
        n_acc   = 0;
        sat_exp = 0;
        @(negedge clk);
        chk("midrst_valid", 32'(m_valid_z), 0);
        @(posedge clk);
        #1;
        reset = 0;
        @(posedge clk);
        #1;
        m_ready_z = 1;
        for (int i = 0; i < 5; i++) send(i * 32);
        drain(20);

        // Random traffic.
        rand_rdy = 1;
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(0, 1) == 0)
                y = int'($urandom_range(0, 262143)) - 131072;
            else
                y = int'($urandom_range(0, 6000)) - 3000;
            send(y);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        rand_rdy = 0;
        #1;
        m_ready_z = 1;
        drain(100);
        chk("rand_sat", 32'(sat_seen), 32'(sat_exp));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
